// File: rtl/hub75_tx_if.sv
// Pixel-pair stream into the HUB75 transmitter: valid/ready handshake plus
// top/bottom pixels ({b,g,r} bytes) and the row address sampled with the
// first pixel of each row.
interface hub75_tx_if;
    logic        pxl_valid;
    logic        pxl_ready;
    logic [23:0] pxl_top;
    logic [23:0] pxl_bot;
    logic [2:0]  pxl_addr;

    modport master (
        output pxl_valid,
        output pxl_top,
        output pxl_bot,
        output pxl_addr,
        input  pxl_ready
    );

    modport slave (
        input  pxl_valid,
        input  pxl_top,
        input  pxl_bot,
        input  pxl_addr,
        output pxl_ready
    );
endinterface

// File: rtl/hub75_tx.sv
// HUB75 LED panel row transmitter. It accepts pixel pairs and shifts each
// colour byte MSB first on sclk. After PIXELS_PER_ROW pixels it pulses le,
// loads the row address and holds oe_n low for OE_CYCLES cycles.
// Optional macro HUB75_TX_BLANK_EN inserts a 2-cycle oe_n-high blank between
// the latch and the display period.
module hub75_tx #(
    parameter int unsigned PIXELS_PER_ROW = 32,
    parameter int unsigned OE_CYCLES      = 64
) (
    input  logic        bclk,
    input  logic        n_reset,
    hub75_tx_if.slave   px,
    output logic        sclk_o,
    output logic [2:0]  rgb_top_o,
    output logic [2:0]  rgb_bot_o,
    output logic [2:0]  addr_o,
    output logic        le_o,
    output logic        oe_n_o,
    output logic        row_done_o
);

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TMR_W  = 16;
    localparam int unsigned ADDR_W = 3;

    typedef enum logic [2:0] {
        WAIT_PX  = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        BLANK    = 3'd4,
        DISPLAY  = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [PIX_W-1:0]    top_q, top_d;
    logic [PIX_W-1:0]    bot_q, bot_d;
    logic [2:0]          idx_q, idx_d;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;

    logic                pxl_ready_q, pxl_ready_d;
    logic                sclk_q, sclk_d;
    logic [2:0]          rgb_top_q, rgb_top_d;
    logic [2:0]          rgb_bot_q, rgb_bot_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                le_q, le_d;
    logic                oe_n_q, oe_n_d;
    logic                row_done_q, row_done_d;

    logic                fire_c;
    logic [CNT_W:0]      pix_next_c;

    // Serial bits {b,g,r} of a packed pixel at the given bit index.
    function automatic logic [2:0] bit_sel(input logic [PIX_W-1:0] pix,
                                           input logic [2:0] idx);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = pix[7:0];
        g = pix[15:8];
        b = pix[23:16];
        return {b[idx], g[idx], r[idx]};
    endfunction

    assign fire_c     = px.pxl_valid && pxl_ready_q;
    assign pix_next_c = {1'b0, pix_cnt_q} + (CNT_W+1)'(1);

    // State register.
    always_ff @(posedge bclk) begin
        if (!n_reset) begin
            state_q <= WAIT_PX;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        top_d      = top_q;
        bot_d      = bot_q;
        idx_d      = idx_q;
        pix_cnt_d  = pix_cnt_q;
        row_addr_d = row_addr_q;
        tmr_d      = tmr_q;
        case (state_q)
            WAIT_PX: begin
                if (fire_c) begin
                    top_d = px.pxl_top;
                    bot_d = px.pxl_bot;
                    idx_d = 3'd7;
                    if (pix_cnt_q == '0) begin
                        row_addr_d = px.pxl_addr;
                    end
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                state_d = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (idx_q != 3'd0) begin
                    idx_d   = idx_q - 3'd1;
                    state_d = SHIFT_LO;
                end else if (pix_next_c < (CNT_W+1)'(PIXELS_PER_ROW)) begin
                    pix_cnt_d = pix_next_c[CNT_W-1:0];
                    state_d   = WAIT_PX;
                end else begin
                    pix_cnt_d = '0;
                    state_d   = LATCH;
                end
            end
            LATCH: begin
                tmr_d = '0;
`ifdef HUB75_TX_BLANK_EN
                state_d = BLANK;
`else
                state_d = DISPLAY;
`endif
            end
            BLANK: begin
                if (tmr_q == TMR_W'(1)) begin
                    tmr_d   = '0;
                    state_d = DISPLAY;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            DISPLAY: begin
                if (tmr_q == TMR_W'(OE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = WAIT_PX;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = WAIT_PX;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs register in step with it.
    always_comb begin
        pxl_ready_d = 1'b0;
        sclk_d      = 1'b0;
        rgb_top_d   = rgb_top_q;
        rgb_bot_d   = rgb_bot_q;
        addr_d      = addr_q;
        le_d        = 1'b0;
        oe_n_d      = 1'b1;
        row_done_d  = 1'b0;
        case (state_d)
            WAIT_PX: begin
                pxl_ready_d = 1'b1;
                row_done_d  = (state_q == DISPLAY);
            end
            SHIFT_LO: begin
                rgb_top_d = bit_sel(top_d, idx_d);
                rgb_bot_d = bit_sel(bot_d, idx_d);
            end
            SHIFT_HI: begin
                sclk_d = 1'b1;
            end
            LATCH: begin
                le_d   = 1'b1;
                addr_d = row_addr_q;
            end
            DISPLAY: begin
                oe_n_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge bclk) begin
        if (!n_reset) begin
            top_q       <= '0;
            bot_q       <= '0;
            idx_q       <= '0;
            pix_cnt_q   <= '0;
            row_addr_q  <= '0;
            tmr_q       <= '0;
            pxl_ready_q <= 1'b0;
            sclk_q      <= 1'b0;
            rgb_top_q   <= '0;
            rgb_bot_q   <= '0;
            addr_q      <= '0;
            le_q        <= 1'b0;
            oe_n_q      <= 1'b1;
            row_done_q  <= 1'b0;
        end else begin
            top_q       <= top_d;
            bot_q       <= bot_d;
            idx_q       <= idx_d;
            pix_cnt_q   <= pix_cnt_d;
            row_addr_q  <= row_addr_d;
            tmr_q       <= tmr_d;
            pxl_ready_q <= pxl_ready_d;
            sclk_q      <= sclk_d;
            rgb_top_q   <= rgb_top_d;
            rgb_bot_q   <= rgb_bot_d;
            addr_q      <= addr_d;
            le_q        <= le_d;
            oe_n_q      <= oe_n_d;
            row_done_q  <= row_done_d;
        end
    end

    assign px.pxl_ready = pxl_ready_q;
    assign sclk_o       = sclk_q;
    assign rgb_top_o    = rgb_top_q;
    assign rgb_bot_o    = rgb_bot_q;
    assign addr_o       = addr_q;
    assign le_o         = le_q;
    assign oe_n_o       = oe_n_q;
    assign row_done_o   = row_done_q;

endmodule

// File: tb/tb_hub75_tx.sv
// Bench for hub75_tx: a 1-pixel-row instance driven from a vector table and a
// 4-pixel-row instance driven by hand sequences, both observed by a panel model.
module tb_hub75_tx;

`ifdef HUB75_TX_BLANK_EN
    localparam int LE_OE_GAP = 3;
`else
    localparam int LE_OE_GAP = 1;
`endif

    typedef struct {
        logic [23:0] top;
        logic [23:0] bot;
        logic [2:0]  a;
        logic [23:0] et;
        logic [23:0] eb;
        logic [2:0]  ea;
    } vec_t;

    logic bclk = 1'b0;
    logic n_reset;
    always #5 bclk = ~bclk;

    logic        v_valid [2];
    logic [23:0] v_top   [2];
    logic [23:0] v_bot   [2];
    logic [2:0]  v_addr  [2];
    logic        rdy     [2];
    logic        sclk_w  [2];
    logic [2:0]  rt_w    [2];
    logic [2:0]  rb_w    [2];
    logic [2:0]  ad_w    [2];
    logic        le_w    [2];
    logic        oen_w   [2];
    logic        rd_w    [2];

    hub75_tx_if if1 ();
    hub75_tx_if if4 ();

    assign if1.pxl_valid = v_valid[0];
    assign if1.pxl_top   = v_top[0];
    assign if1.pxl_bot   = v_bot[0];
    assign if1.pxl_addr  = v_addr[0];
    assign rdy[0]        = if1.pxl_ready;
    assign if4.pxl_valid = v_valid[1];
    assign if4.pxl_top   = v_top[1];
    assign if4.pxl_bot   = v_bot[1];
    assign if4.pxl_addr  = v_addr[1];
    assign rdy[1]        = if4.pxl_ready;

    hub75_tx #(.PIXELS_PER_ROW(1), .OE_CYCLES(64)) u1 (
        .bclk(bclk), .n_reset(n_reset), .px(if1),
        .sclk_o(sclk_w[0]), .rgb_top_o(rt_w[0]), .rgb_bot_o(rb_w[0]),
        .addr_o(ad_w[0]), .le_o(le_w[0]), .oe_n_o(oen_w[0]), .row_done_o(rd_w[0])
    );

    hub75_tx #(.PIXELS_PER_ROW(4), .OE_CYCLES(64)) u4 (
        .bclk(bclk), .n_reset(n_reset), .px(if4),
        .sclk_o(sclk_w[1]), .rgb_top_o(rt_w[1]), .rgb_bot_o(rb_w[1]),
        .addr_o(ad_w[1]), .le_o(le_w[1]), .oe_n_o(oen_w[1]), .row_done_o(rd_w[1])
    );

    // Panel model: shift on sclk rise, latch on le rise, count oe/row_done.
    logic [63:0] acc [2][6] = '{default: '0};
    logic [63:0] lat [2][6] = '{default: '0};
    logic [2:0]  lat_addr [2] = '{default: '0};
    logic        sclk_p [2] = '{default: 1'b0};
    logic        le_p   [2] = '{default: 1'b0};
    logic        oe_wait [2] = '{default: 1'b0};
    int edge_cnt [2] = '{default: 0};
    int le_cnt   [2] = '{default: 0};
    int oe_cnt   [2] = '{default: 0};
    int rd_cnt   [2] = '{default: 0};
    int le_cyc   [2] = '{default: 0};
    int oe_cyc   [2] = '{default: 0};
    int cyc = 0;

    always @(negedge bclk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (sclk_w[d] && !sclk_p[d]) begin
                edge_cnt[d] <= edge_cnt[d] + 1;
                for (int ch = 0; ch < 3; ch++) begin
                    acc[d][ch]   <= {acc[d][ch][62:0], rt_w[d][ch]};
                    acc[d][ch+3] <= {acc[d][ch+3][62:0], rb_w[d][ch]};
                end
            end
            if (le_w[d] && !le_p[d]) begin
                le_cnt[d]   <= le_cnt[d] + 1;
                le_cyc[d]   <= cyc;
                oe_wait[d]  <= 1'b1;
                lat_addr[d] <= ad_w[d];
                for (int ch = 0; ch < 6; ch++) lat[d][ch] <= acc[d][ch];
            end
            if (!oen_w[d]) oe_cnt[d] <= oe_cnt[d] + 1;
            if (!oen_w[d] && oe_wait[d]) begin
                oe_cyc[d]  <= cyc;
                oe_wait[d] <= 1'b0;
            end
            if (rd_w[d]) rd_cnt[d] <= rd_cnt[d] + 1;
            sclk_p[d] <= sclk_w[d];
            le_p[d]   <= le_w[d];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int d, input string name);
        chk(name, 128'({rdy[d], sclk_w[d], rt_w[d], rb_w[d], ad_w[d], le_w[d], oen_w[d], rd_w[d]}),
            128'(14'h0002));
    endtask

    // Pixel k (0 = first shifted) of an n-pixel row from the latched panel data.
    function automatic logic [23:0] pix_of(input int d, input bit top, input int n, input int k);
        int sh;
        int base;
        sh   = 8 * (n - 1 - k);
        base = top ? 0 : 3;
        return {lat[d][base+2][sh +: 8], lat[d][base+1][sh +: 8], lat[d][base][sh +: 8]};
    endfunction

    // Present one pixel pair (called at a negedge); returns at the negedge after acceptance.
    task automatic send(input int d, input logic [23:0] t, input logic [23:0] b, input logic [2:0] a);
        int n;
        v_top[d] = t; v_bot[d] = b; v_addr[d] = a; v_valid[d] = 1'b1;
        n = 0;
        while (!rdy[d] && n < 2000) begin
            @(negedge bclk);
            n++;
        end
        if (!rdy[d]) begin
            total++; bad++;
            $display("FAIL send_timeout: dut %0d ready never rose", d);
        end
        @(negedge bclk);
        v_valid[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        int n;
        n = 0;
        while (!rd_w[d] && n < 2000) begin
            @(negedge bclk);
            n++;
        end
        if (!rd_w[d]) begin
            total++; bad++;
            $display("FAIL row_done_timeout: dut %0d", d);
        end
        @(negedge bclk);
    endtask

    vec_t        tbl [5];
    logic [23:0] pt [4];
    logic [23:0] pb [4];
    int s_e, s_le, s_oe, s_rd, stall_bad;
    logic [6:0]  hold;

    initial begin
        tbl[0] = '{24'hC35A81, 24'h00FF0F, 3'd5, 24'hC35A81, 24'h00FF0F, 3'd5};
        tbl[1] = '{24'hFFFFFF, 24'h000000, 3'd7, 24'hFFFFFF, 24'h000000, 3'd7};
        tbl[2] = '{24'h000000, 24'hFFFFFF, 3'd0, 24'h000000, 24'hFFFFFF, 3'd0};
        tbl[3] = '{24'h123456, 24'hABCDEF, 3'd2, 24'h123456, 24'hABCDEF, 3'd2};
        tbl[4] = '{24'h800001, 24'h010080, 3'd6, 24'h800001, 24'h010080, 3'd6};

        n_reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            v_valid[d] = 1'b0; v_top[d] = '0; v_bot[d] = '0; v_addr[d] = '0;
        end
        repeat (3) @(negedge bclk);
        chk_reset(0, "reset_u1");
        chk_reset(1, "reset_u4");
        n_reset = 1'b1;
        @(negedge bclk);
        chk("ready_after_reset", 128'(rdy[1]), 128'(1'b1));

        // One-pixel rows from the table.
        for (int i = 0; i < 5; i++) begin
            s_e = edge_cnt[0];
            send(0, tbl[i].top, tbl[i].bot, tbl[i].a);
            wait_done(0);
            chk($sformatf("v%0d_top", i),   128'(pix_of(0, 1'b1, 1, 0)), 128'(tbl[i].et));
            chk($sformatf("v%0d_bot", i),   128'(pix_of(0, 1'b0, 1, 0)), 128'(tbl[i].eb));
            chk($sformatf("v%0d_addr", i),  128'(lat_addr[0]), 128'(tbl[i].ea));
            chk($sformatf("v%0d_edges", i), 128'(edge_cnt[0] - s_e), 128'(8));
        end
        chk("le_to_oe_gap", 128'(oe_cyc[0] - le_cyc[0]), 128'(LE_OE_GAP));

        // Row A: four pixels, continuous valid, address 5.
        pt = '{24'h102030, 24'hA5A5A5, 24'h0F0F0F, 24'hFEDCBA};
        pb = '{24'h010203, 24'h5A5A5A, 24'hF0F0F0, 24'h123456};
        s_e = edge_cnt[1]; s_le = le_cnt[1]; s_oe = oe_cnt[1]; s_rd = rd_cnt[1];
        for (int k = 0; k < 4; k++) send(1, pt[k], pb[k], 3'd5);
        wait_done(1);
        chk("rowA_edges",    128'(edge_cnt[1] - s_e), 128'(32));
        chk("rowA_le",       128'(le_cnt[1] - s_le),  128'(1));
        chk("rowA_oe_low",   128'(oe_cnt[1] - s_oe),  128'(64));
        chk("rowA_row_done", 128'(rd_cnt[1] - s_rd),  128'(1));
        chk("rowA_top", 128'({pix_of(1,1'b1,4,0), pix_of(1,1'b1,4,1), pix_of(1,1'b1,4,2), pix_of(1,1'b1,4,3)}),
            128'({pt[0], pt[1], pt[2], pt[3]}));
        chk("rowA_bot", 128'({pix_of(1,1'b0,4,0), pix_of(1,1'b0,4,1), pix_of(1,1'b0,4,2), pix_of(1,1'b0,4,3)}),
            128'({pb[0], pb[1], pb[2], pb[3]}));
        chk("rowA_addr", 128'(ad_w[1]), 128'(3'd5));

        // Row B: address 3, upstream stall of 20 cycles between pixels 2 and 3.
        pt = '{24'h111111, 24'h876543, 24'hC0FFEE, 24'h00000F};
        pb = '{24'hFEDCBA, 24'h2468AC, 24'h13579B, 24'hF00000};
        send(1, pt[0], pb[0], 3'd3);
        send(1, pt[1], pb[1], 3'd3);
        begin : stall_seq
            int n;
            n = 0;
            while (!rdy[1] && n < 100) begin
                @(negedge bclk);
                n++;
            end
        end
        chk("stall_ready", 128'(rdy[1]), 128'(1'b1));
        hold = {sclk_w[1], rt_w[1], rb_w[1]};
        chk("stall_last_bits", 128'(hold),
            128'({1'b0, pt[1][16], pt[1][8], pt[1][0], pb[1][16], pb[1][8], pb[1][0]}));
        stall_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge bclk);
            if ({sclk_w[1], rt_w[1], rb_w[1]} !== hold) stall_bad++;
        end
        chk("stall_hold", 128'(stall_bad), 128'(0));
        chk("addr_held_mid_row", 128'(ad_w[1]), 128'(3'd5));
        send(1, pt[2], pb[2], 3'd1);
        send(1, pt[3], pb[3], 3'd1);
        wait_done(1);
        chk("rowB_top", 128'({pix_of(1,1'b1,4,0), pix_of(1,1'b1,4,1), pix_of(1,1'b1,4,2), pix_of(1,1'b1,4,3)}),
            128'({pt[0], pt[1], pt[2], pt[3]}));
        chk("rowB_bot", 128'({pix_of(1,1'b0,4,0), pix_of(1,1'b0,4,1), pix_of(1,1'b0,4,2), pix_of(1,1'b0,4,3)}),
            128'({pb[0], pb[1], pb[2], pb[3]}));
        chk("rowB_latched_addr", 128'(lat_addr[1]), 128'(3'd3));
        chk("rowB_addr", 128'(ad_w[1]), 128'(3'd3));

        // Reset during bit 4 of pixel 2, then a clean row from pixel 1.
        send(1, 24'hAAAAAA, 24'h555555, 3'd7);
        send(1, 24'hCCCCCC, 24'h333333, 3'd7);
        repeat (6) @(negedge bclk);
        n_reset = 1'b0;
        @(negedge bclk);
        chk_reset(1, "reset_mid_shift");
        n_reset = 1'b1;
        @(negedge bclk);
        chk("ready_after_abort", 128'(rdy[1]), 128'(1'b1));
        pt = '{24'h0A0B0C, 24'hDEADBE, 24'h7F8001, 24'h00FF00};
        pb = '{24'hC0C0C0, 24'h0102A0, 24'h99AA55, 24'hFF0000};
        s_le = le_cnt[1];
        for (int k = 0; k < 4; k++) send(1, pt[k], pb[k], 3'd6);
        wait_done(1);
        chk("rowC_le", 128'(le_cnt[1] - s_le), 128'(1));
        chk("rowC_top", 128'({pix_of(1,1'b1,4,0), pix_of(1,1'b1,4,1), pix_of(1,1'b1,4,2), pix_of(1,1'b1,4,3)}),
            128'({pt[0], pt[1], pt[2], pt[3]}));
        chk("rowC_bot", 128'({pix_of(1,1'b0,4,0), pix_of(1,1'b0,4,1), pix_of(1,1'b0,4,2), pix_of(1,1'b0,4,3)}),
            128'({pb[0], pb[1], pb[2], pb[3]}));
        chk("rowC_addr", 128'(lat_addr[1]), 128'(3'd6));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hub75_tx.md
HUB75_TX -- requirements
Module: hub75_tx

Interface
REQ-001 Parameter PIXELS_PER_ROW, default 32, meaning pixels shifted per row before latch (legal 1..256).
REQ-002 Parameter OE_CYCLES, default 64, meaning bclk cycles oe_n is held low per row (legal 1..65535).
REQ-003 bclk  input  1  block clock; all state updates on rising edge.
REQ-004 n_reset  input  1  reset, synchronous, active-low.
REQ-005 pxl_valid  input  1  upstream pixel pair available.
REQ-006 pxl_ready  output  1  block accepts a pixel pair this cycle.
REQ-007 pxl_top  input  24  top-half pixel, packed {b[7:0], g[7:0], r[7:0]}.
REQ-008 pxl_bot  input  24  bottom-half pixel, same packing.
REQ-009 pxl_addr  input  3  row address; sampled with the first pixel of each row only.
REQ-010 sclk  output  1  panel shift clock; panel samples rgb on its rising edge.
REQ-011 rgb_top  output  3  serial top data: [0]=r, [1]=g, [2]=b.
REQ-012 rgb_bot  output  3  serial bottom data, same bit mapping.
REQ-013 addr  output  3  panel row address.
REQ-014 le  output  1  latch enable, active-high.
REQ-015 oe_n  output  1  output enable, active-low.
REQ-016 row_done  output  1  one-cycle pulse when a row's display period ends.

Function
REQ-017 FSM states SHALL be WAIT_PX, SHIFT_LO, SHIFT_HI, LATCH, BLANK, DISPLAY.
REQ-018 WAIT_PX: pxl_ready=1; on pxl_valid&&pxl_ready, capture both pixels into shift registers, bit index=7, go SHIFT_LO next cycle.
REQ-019 pxl_ready SHALL be 0 in every state other than WAIT_PX; pxl_valid without ready SHALL have no effect.
REQ-020 SHIFT_LO: sclk=0, rgb_top/rgb_bot driven with bit[index] of r,g,b channels; next state SHIFT_HI.
REQ-021 SHIFT_HI: sclk=1, rgb unchanged from SHIFT_LO; if index>0 decrement and go SHIFT_LO; else pixel complete.
REQ-022 Bit order SHALL be MSB first: bit 7 shifted first, bit 0 last; 8 sclk rising edges, 16 bclk cycles per pixel.
REQ-023 Pixel counter (8-bit) SHALL increment on pixel complete; if count<PIXELS_PER_ROW go WAIT_PX, else clear counter and go LATCH.
REQ-024 LATCH: le=1 for exactly one cycle, sclk=0; addr SHALL load the row address captured with the row's first pixel.
REQ-025 DISPLAY: oe_n=0 for exactly OE_CYCLES cycles, then oe_n=1, row_done=1 for one cycle, state WAIT_PX.
REQ-026 oe_n SHALL be 1 in all states except DISPLAY; le SHALL be 0 except LATCH.
REQ-027 Upstream stall mid-row (pxl_valid=0 in WAIT_PX) SHALL hold sclk=0 and rgb at last value indefinitely.
REQ-028 PIXELS_PER_ROW=1 SHALL produce one pixel then LATCH with no wrap error.

Reset
REQ-029 n_reset=0 at a bclk edge SHALL force state WAIT_PX, counters 0, captured address 0 on that edge.
REQ-030 Reset values: pxl_ready=0, sclk=0, rgb_top=0, rgb_bot=0, addr=0, le=0, oe_n=1, row_done=0.
REQ-031 Reset asserted mid-shift, mid-latch or mid-display SHALL abort immediately; partial pixel/row discarded.
REQ-032 pxl_ready SHALL rise on the first cycle after n_reset returns high.

Configuration
REQ-033 Macro HUB75_TX_BLANK_EN: when defined, LATCH SHALL go to BLANK, holding oe_n=1 for 2 cycles before DISPLAY (ghosting guard).
REQ-034 Without HUB75_TX_BLANK_EN, BLANK SHALL be unreachable and LATCH SHALL go directly to DISPLAY.

Verification
REQ-035 PIXELS_PER_ROW=1, pxl_top=24'hC3_5A_81, pxl_bot=24'h00_FF_0F, addr 5 -> panel model captures top 24'hC35A81, bottom 24'h00FF0F, addr 5 after le.
REQ-036 PIXELS_PER_ROW=4, continuous valid -> exactly 32 sclk rising edges, one le pulse, oe_n low 64 cycles, one row_done.
REQ-037 pxl_valid dropped 20 cycles between pixels 2 and 3 -> sclk low and rgb stable throughout stall, data intact.
REQ-038 n_reset low during bit 4 of pixel 2 -> all outputs at reset values next edge; following row received correctly from pixel 1.
REQ-039 HUB75_TX_BLANK_EN defined -> 2 cycles oe_n=1 between le falling and oe_n low; undefined -> oe_n low cycle after le.
REQ-040 Second row pxl_addr=3 while first row displays with addr=5 -> addr stays 5 until second row LATCH, then 3.
